// File: rtl/imm_gen_pkg.sv
// Shared constants for the immediate generator: base opcodes, immediate type codes,
// RVC quadrant/funct3 encodings and the skid-buffer state encoding.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_U       = 3'b000,
    IMM_I       = 3'b001,
    IMM_SHIFT   = 3'b010,
    IMM_S       = 3'b011,
    IMM_B       = 3'b100,
    IMM_J       = 3'b101,
    IMM_NONE    = 3'b110,
    IMM_INVALID = 3'b111
  } imm_type_e;

  localparam logic [1:0] RVC_Q0 = 2'b00;
  localparam logic [1:0] RVC_Q1 = 2'b01;

  localparam logic [2:0] C0_F3_LW   = 3'b010;
  localparam logic [2:0] C0_F3_SW   = 3'b110;
  localparam logic [2:0] C1_F3_ADDI = 3'b000;
  localparam logic [2:0] C1_F3_LI   = 3'b010;
  localparam logic [2:0] C1_F3_LUI  = 3'b011;
  localparam logic [2:0] C1_F3_J    = 3'b101;
  localparam logic [2:0] C1_F3_BEQZ = 3'b110;
  localparam logic [2:0] C1_F3_BNEZ = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } stage_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: classifies the opcode and builds the extended immediate.
// Optional RVC decode is enabled by defining IMM_GEN_RVC_EN.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm_c,
  output logic [2:0]      imm_type_c,
  output logic            illegal_c
);

  logic [31:0] imm32;
  logic        sext;
  imm_type_e   typ;
  logic [2:0]  funct3;

  assign funct3 = instr[14:12];

  // imm32 holds the 32-bit form; sext selects sign- or zero-extension to XLEN
  always_comb begin
    imm32 = '0;
    sext  = 1'b0;
    typ   = IMM_INVALID;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        OPC_LUI, OPC_AUIPC: begin
          imm32 = {instr[31:12], 12'b0};
          sext  = 1'b1;
          typ   = IMM_U;
        end
        OPC_OP_IMM: begin
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            imm32 = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
            typ   = IMM_SHIFT;
          end else begin
            imm32 = {{20{instr[31]}}, instr[31:20]};
            sext  = 1'b1;
            typ   = IMM_I;
          end
        end
        OPC_LOAD, OPC_JALR: begin
          imm32 = {{20{instr[31]}}, instr[31:20]};
          sext  = 1'b1;
          typ   = IMM_I;
        end
        OPC_STORE: begin
          imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
          sext  = 1'b1;
          typ   = IMM_S;
        end
        OPC_BRANCH: begin
          imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
          sext  = 1'b1;
          typ   = IMM_B;
        end
        OPC_JAL: begin
          imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
          sext  = 1'b1;
          typ   = IMM_J;
        end
        OPC_OP: typ = IMM_NONE;
        default: typ = IMM_INVALID;
      endcase
    end else begin
`ifdef IMM_GEN_RVC_EN
      case ({instr[1:0], instr[15:13]})
        {RVC_Q1, C1_F3_ADDI}, {RVC_Q1, C1_F3_LI}: begin
          imm32 = {{26{instr[12]}}, instr[12], instr[6:2]};
          sext  = 1'b1;
          typ   = IMM_I;
        end
        {RVC_Q1, C1_F3_LUI}: begin
          // rd=2 is C.ADDI16SP and rd=0 is reserved; neither is supported here
          if (instr[11:7] != 5'd0 && instr[11:7] != 5'd2) begin
            imm32 = {{14{instr[12]}}, instr[12], instr[6:2], 12'b0};
            sext  = 1'b1;
            typ   = IMM_U;
          end
        end
        {RVC_Q0, C0_F3_LW}: begin
          imm32 = {25'b0, instr[5], instr[12:10], instr[6], 2'b0};
          typ   = IMM_I;
        end
        {RVC_Q0, C0_F3_SW}: begin
          imm32 = {25'b0, instr[5], instr[12:10], instr[6], 2'b0};
          typ   = IMM_S;
        end
        {RVC_Q1, C1_F3_J}: begin
          imm32 = {{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6], instr[7],
                   instr[2], instr[11], instr[5:3], 1'b0};
          sext  = 1'b1;
          typ   = IMM_J;
        end
        {RVC_Q1, C1_F3_BEQZ}, {RVC_Q1, C1_F3_BNEZ}: begin
          imm32 = {{23{instr[12]}}, instr[12], instr[6:5], instr[2], instr[11:10],
                   instr[4:3], 1'b0};
          sext  = 1'b1;
          typ   = IMM_B;
        end
        default: typ = IMM_INVALID;
      endcase
`else
      typ = IMM_INVALID;
`endif
    end
  end

  assign imm_c      = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);
  assign imm_type_c = typ;
  assign illegal_c  = (typ == IMM_INVALID);

endmodule

// File: rtl/immediate_gen_stage.sv
// Pipeline stage wrapping imm_decode in a 2-entry skid buffer with registered in_ready.
// Optional RVC decode is enabled by defining IMM_GEN_RVC_EN.
module immediate_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_imm_type,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_type;
  logic             dec_illegal;

  stage_state_e     state;
  logic [XLEN-1:0]  skid_imm;
  logic [2:0]       skid_type;
  logic             skid_illegal;
  logic [TAG_W-1:0] skid_tag;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr      (in_instr),
    .imm_c      (dec_imm),
    .imm_type_c (dec_type),
    .illegal_c  (dec_illegal)
  );

  // Main register drives the outputs directly; skid catches one entry under backpressure
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      state        <= ST_EMPTY;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_imm_type <= IMM_NONE;
      out_illegal  <= 1'b0;
      out_tag      <= '0;
      skid_imm     <= '0;
      skid_type    <= IMM_NONE;
      skid_illegal <= 1'b0;
      skid_tag     <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_valid) begin
            out_imm      <= dec_imm;
            out_imm_type <= dec_type;
            out_illegal  <= dec_illegal;
            out_tag      <= in_tag;
            out_valid    <= 1'b1;
            state        <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_valid && out_ready) begin
            out_imm      <= dec_imm;
            out_imm_type <= dec_type;
            out_illegal  <= dec_illegal;
            out_tag      <= in_tag;
          end else if (in_valid) begin
            skid_imm     <= dec_imm;
            skid_type    <= dec_type;
            skid_illegal <= dec_illegal;
            skid_tag     <= in_tag;
            in_ready     <= 1'b0;
            state        <= ST_FULL;
          end else if (out_ready) begin
            out_valid    <= 1'b0;
            state        <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            out_imm      <= skid_imm;
            out_imm_type <= skid_type;
            out_illegal  <= skid_illegal;
            out_tag      <= skid_tag;
            in_ready     <= 1'b1;
            state        <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_immediate_gen_stage.sv
// Directed bench for immediate_gen_stage: decode vectors, backpressure, flush, reset and XLEN=64.
module tb_immediate_gen_stage;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [2:0]  out_imm_type;
  logic        out_illegal;
  logic [31:0] out_tag;

  logic        in_valid64;
  logic        in_ready64;
  logic [31:0] in_instr64;
  logic [31:0] in_tag64;
  logic        out_valid64;
  logic        out_ready64;
  logic [63:0] out_imm64;
  logic [2:0]  out_imm_type64;
  logic        out_illegal64;
  logic [31:0] out_tag64;

  int pass_cnt = 0;
  int total_cnt = 0;

  immediate_gen_stage #(.XLEN(32), .TAG_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_imm      (out_imm),
    .out_imm_type (out_imm_type),
    .out_illegal  (out_illegal),
    .out_tag      (out_tag)
  );

  immediate_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .in_valid     (in_valid64),
    .in_ready     (in_ready64),
    .in_instr     (in_instr64),
    .in_tag       (in_tag64),
    .out_valid    (out_valid64),
    .out_ready    (out_ready64),
    .out_imm      (out_imm64),
    .out_imm_type (out_imm_type64),
    .out_illegal  (out_illegal64),
    .out_tag      (out_tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b expected 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_imm !== 32'h0) $display("FAIL reset out_imm: got %h expected 0", out_imm); else pass_cnt++;
    total_cnt++; if (out_imm_type !== 3'b110) $display("FAIL reset out_imm_type: got %b expected 110", out_imm_type); else pass_cnt++;
    total_cnt++; if (out_illegal !== 1'b0) $display("FAIL reset out_illegal: got %b expected 0", out_illegal); else pass_cnt++;
    total_cnt++; if (out_tag !== 32'h0) $display("FAIL reset out_tag: got %h expected 0", out_tag); else pass_cnt++;
    total_cnt++; if (out_valid64 !== 1'b0) $display("FAIL reset out_valid64: got %b expected 0", out_valid64); else pass_cnt++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_decode();
    logic [31:0] v_instr [10] = '{32'hFFF00093, 32'hFE112E23, 32'hFFDFF06F, 32'h4030D093,
                                  32'h0000007F, 32'h800002B7, 32'hFE000EE3, 32'h002081B3,
                                  32'h00004501, 32'h02009093};
    logic [31:0] v_imm   [10] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000003,
                                  32'h00000000, 32'h80000000, 32'hFFFFFFFC, 32'h00000000,
                                  32'h00000000, 32'h00000000};
    logic [2:0]  v_type  [10] = '{3'b001, 3'b011, 3'b101, 3'b010, 3'b111,
                                  3'b000, 3'b100, 3'b110, 3'b111, 3'b010};
    logic        v_ill   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_instr = v_instr[i];
      in_tag   = 32'h1000 + 32'(i);
      step();
      in_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL decode[%0d] out_valid: got %b expected 1", i, out_valid); else pass_cnt++;
      total_cnt++; if (out_imm !== v_imm[i]) $display("FAIL decode[%0d] out_imm: got %h expected %h", i, out_imm, v_imm[i]); else pass_cnt++;
      total_cnt++; if (out_imm_type !== v_type[i]) $display("FAIL decode[%0d] out_imm_type: got %b expected %b", i, out_imm_type, v_type[i]); else pass_cnt++;
      total_cnt++; if (out_illegal !== v_ill[i]) $display("FAIL decode[%0d] out_illegal: got %b expected %b", i, out_illegal, v_ill[i]); else pass_cnt++;
      total_cnt++; if (out_tag !== 32'h1000 + 32'(i)) $display("FAIL decode[%0d] out_tag: got %h expected %h", i, out_tag, 32'h1000 + 32'(i)); else pass_cnt++;
      step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL decode[%0d] drain out_valid: got %b expected 0", i, out_valid); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_imm [3] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000003};
    logic [31:0] exp_tag [3] = '{32'hA1, 32'hA2, 32'hA3};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    in_tag    = 32'hA1;
    step();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp in_ready after 1st: got %b expected 1", in_ready); else pass_cnt++;
    in_instr = 32'hFE112E23;
    in_tag   = 32'hA2;
    step();
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp in_ready after 2nd: got %b expected 0", in_ready); else pass_cnt++;
    in_instr = 32'h4030D093;
    in_tag   = 32'hA3;
    step();
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp in_ready held: got %b expected 0", in_ready); else pass_cnt++;
    total_cnt++; if (out_tag !== 32'hA1) $display("FAIL bp stable out_tag: got %h expected a1", out_tag); else pass_cnt++;
    total_cnt++; if (out_imm !== 32'hFFFFFFFF) $display("FAIL bp stable out_imm: got %h expected ffffffff", out_imm); else pass_cnt++;
    // Third word stays offered; it is accepted only once in_ready returns
    out_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      step();
      if (k == 2) in_valid = 1'b0;
      total_cnt++; if (out_tag !== exp_tag[k]) $display("FAIL bp order[%0d] out_tag: got %h expected %h", k, out_tag, exp_tag[k]); else pass_cnt++;
      total_cnt++; if (out_imm !== exp_imm[k]) $display("FAIL bp order[%0d] out_imm: got %h expected %h", k, out_imm, exp_imm[k]); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp order[%0d] out_valid: got %b expected 1", k, out_valid); else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp final out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp final in_ready: got %b expected 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    in_tag    = 32'hB1;
    step();
    in_tag = 32'hB2;
    step();
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush setup in_ready: got %b expected 0", in_ready); else pass_cnt++;
    in_tag = 32'hBAD;
    flush  = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush full out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush full in_ready: got %b expected 1", in_ready); else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush ghost[%0d] out_valid: got %b tag %h expected 0", k, out_valid, out_tag); else pass_cnt++;
    end
    // Flush in ONE overrides a same-cycle accept
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 32'hC1;
    step();
    in_tag = 32'hC2;
    flush  = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush one out_valid: got %b expected 0", out_valid); else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush one ghost out_valid: got %b expected 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFE112E23;
    in_tag    = 32'hD1;
    step();
    in_tag = 32'hD2;
    step();
    in_tag  = 32'hD3;
    reset_n = 1'b0;
    flush   = 1'b1;
    step();
    reset_n  = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rstmid in_ready: got %b expected 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_tag !== 32'h0) $display("FAIL rstmid out_tag: got %h expected 0", out_tag); else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid ghost out_valid: got %b expected 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_xlen64();
    logic [31:0] v_instr [4] = '{32'h800002B7, 32'hFFF00093, 32'h02009093, 32'hFFDFF06F};
    logic [63:0] v_imm   [4] = '{64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF,
                                 64'h0000000000000020, 64'hFFFFFFFFFFFFFFFC};
    logic [2:0]  v_type  [4] = '{3'b000, 3'b001, 3'b010, 3'b101};
    out_ready64 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid64 = 1'b1;
      in_instr64 = v_instr[i];
      in_tag64   = 32'h6400 + 32'(i);
      step();
      in_valid64 = 1'b0;
      total_cnt++; if (out_valid64 !== 1'b1) $display("FAIL x64[%0d] out_valid: got %b expected 1", i, out_valid64); else pass_cnt++;
      total_cnt++; if (out_imm64 !== v_imm[i]) $display("FAIL x64[%0d] out_imm: got %h expected %h", i, out_imm64, v_imm[i]); else pass_cnt++;
      total_cnt++; if (out_imm_type64 !== v_type[i]) $display("FAIL x64[%0d] out_imm_type: got %b expected %b", i, out_imm_type64, v_type[i]); else pass_cnt++;
      total_cnt++; if (out_tag64 !== 32'h6400 + 32'(i)) $display("FAIL x64[%0d] out_tag: got %h expected %h", i, out_tag64, 32'h6400 + 32'(i)); else pass_cnt++;
      step();
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_instr    = '0;
    in_tag      = '0;
    out_ready   = 1'b0;
    in_valid64  = 1'b0;
    in_instr64  = '0;
    in_tag64    = '0;
    out_ready64 = 1'b0;
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_xlen64();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/immediate_gen_stage.md
IMMEDIATE_GEN_STAGE -- requirements
Module: immediate_gen_stage

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 32, width of the sideband tag (e.g. PC) carried with each instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 flush  input  1  synchronous pipeline flush; discards all held entries.
REQ-006 in_valid  input  1  instruction word and tag are valid.
REQ-007 in_ready  output  1  stage can accept an input this cycle.
REQ-008 in_instr  input  32  instruction word.
REQ-009 in_tag  input  TAG_W  sideband tag, passed through unmodified.
REQ-010 out_valid  output  1  output entry is valid.
REQ-011 out_ready  input  1  consumer accepts the output entry this cycle.
REQ-012 out_imm  output  XLEN  extended immediate.
REQ-013 out_imm_type  output  3  type code: U=000, I=001, SHIFT=010, S=011, B=100, J=101, NONE=110, INVALID=111.
REQ-014 out_illegal  output  1  opcode not recognised.
REQ-015 out_tag  output  TAG_W  tag of the output entry.

Function
REQ-016 The block SHALL derive the type from in_instr[6:0]; it SHALL NOT take a select input.
- LUI 0110111 and AUIPC 0010111 -> U.
- OP-IMM 0010011 -> SHIFT if funct3 is 001 or 101, else I.
- LOAD 0000011 and JALR 1100111 -> I.
- STORE 0100011 -> S; BRANCH 1100011 -> B; JAL 1101111 -> J; OP 0110011 -> NONE.
- Any other opcode -> INVALID.
REQ-017 I, S, B and J immediates SHALL be sign-extended from instr[31] to XLEN; B and J SHALL have bit 0 = 0.
REQ-018 U SHALL be {instr[31:12], 12'b0}, sign-extended to XLEN when XLEN=64.
REQ-019 SHIFT SHALL be zero-extended shamt: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
REQ-020 NONE and INVALID SHALL produce out_imm=0; out_illegal SHALL be 1 only for INVALID.
REQ-021 Handshake: a transfer occurs when valid and ready are both high; latency from input transfer to out_valid SHALL be exactly 1 cycle.
REQ-022 Buffering SHALL be a 2-entry skid buffer (main + skid register): in_ready = !skid_full, registered, with no combinational path from out_ready.
REQ-023 States: EMPTY (out_valid=0), ONE (main full), FULL (main+skid full).
- EMPTY->ONE on input accept.
- ONE->FULL on accept with !out_ready.
- ONE->EMPTY on output accept with no input.
- ONE stays ONE on simultaneous accept in and out.
- FULL->ONE on output accept; skid moves to main.
REQ-024 Order SHALL be preserved; no entry is dropped or duplicated under any out_ready pattern.
REQ-025 Output fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 flush SHALL clear the stage to EMPTY at the next edge and override a same-cycle input accept; the flushed input is discarded.

Reset
REQ-027 While reset_n=0 at an edge, the state SHALL go to EMPTY.
- out_valid=0, in_ready=1 from the next cycle.
- out_imm=0, out_imm_type=110, out_illegal=0, out_tag=0.
REQ-028 Reset mid-transfer SHALL discard all held entries; reset has priority over flush and input accept.

Configuration
REQ-029 Macro IMM_GEN_RVC_EN.
- When defined: an input with in_instr[1:0]!=11 SHALL be decoded as a 16-bit RVC instruction from in_instr[15:0]. Supported: C.ADDI and C.LI -> I, C.LUI -> U (sign-extended nzimm<<12), C.LW and C.SW -> I/S (zero-extended uimm), C.J -> J, C.BEQZ and C.BNEZ -> B. Any other RVC encoding -> INVALID.
- When undefined: such inputs SHALL be INVALID with out_illegal=1.

Structure
REQ-030 Package imm_gen_pkg SHALL hold the opcode constants, the 3-bit type codes and the RVC quadrant/funct3 constants.
REQ-031 Combinational decode SHALL live in sub-module imm_decode (instr in; imm, type, illegal out); immediate_gen_stage holds only the handshake and registers.

Verification
REQ-032 in_instr=0xFFF00093 (addi -1) with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, type=001.
REQ-033 0xFE112E23 (sw -4) -> 0xFFFFFFFC, type 011; 0xFFDFF06F (jal -4) -> 0xFFFFFFFC, type 101; 0x4030D093 (srai 3) -> 0x00000003, type 010.
REQ-034 Backpressure test: stream 3 instructions with out_ready=0. Required: in_ready drops after the 2nd accept and the 3rd is held. Then raise out_ready: 3 outputs arrive in order with their tags intact.
REQ-035 Flush test: assert flush in FULL while in_valid=1. Required: next cycle out_valid=0, in_ready=1, and the flushed input never appears.
REQ-036 Illegal and XLEN test: opcode 0x7F -> type 111, out_illegal=1, imm=0. With XLEN=64, lui 0x80000 -> 0xFFFFFFFF80000000.
